// File: rtl/frame_buffer_ctrl.sv
// ============================================================================
// frame_buffer_ctrl
// ----------------------------------------------------------------------------
// Double-buffered frame buffer controller between the particle renderer and
// the TMDS encoders. The producer writes (x, y, colour) pixels into the back
// bank through a valid/ready handshake. The back bank is hardware-cleared
// after every swap. The front bank is scanned out against the video timing
// at 1x, 2x or 4x integer scale. A producer swap request only takes effect
// on the frame boundary, so a half-drawn frame is never shown.
//
// Handshake: a pixel write transfers on a rising clk_pixel edge where both
// px_valid_in and px_ready_out are high. px_ready_out is high only in DRAW
// and does not depend on px_valid_in.
//
// Ports
//   clk_pixel         pixel clock, the only clock
//   rst_in            asynchronous, active-low reset
//   hcount_in         horizontal count from the video timing generator
//   vcount_in         vertical count from the video timing generator
//   active_draw_in    active video region
//   scale_sel         0=1x, 1=2x, 2/3=4x scanout scale
//   px_x_in/px_y_in   write coordinate
//   px_color_in       write colour
//   px_valid_in       write request
//   px_ready_out      write accepted when valid and ready are both high
//   swap_req_in       one-cycle pulse: producer finished the frame
//   pixel_out         scanout pixel, 0 outside the buffer region
//   pixel_valid_out   pixel_out comes from the buffer region
//   front_sel_out     bank currently displayed
//   clearing_out      back-bank clear in progress
//   swap_pending_out  swap requested, not yet taken
//   drop_count_out    saturating count of out-of-range writes
// ============================================================================
module frame_buffer_ctrl #(
  parameter int                 FB_WIDTH    = 320,
  parameter int                 FB_HEIGHT   = 180,
  parameter int                 PIXEL_W     = 16,
  parameter logic [PIXEL_W-1:0] CLEAR_COLOR = '0,
  parameter int                 H_ACTIVE    = 1280,
  parameter int                 V_ACTIVE    = 720,
  // Coordinate ports carry one code point beyond the buffer edge so that an
  // out-of-range write is representable even when a dimension is a power of
  // two; at the default sizes this equals $clog2 of the dimension.
  localparam int                XW          = $clog2(FB_WIDTH + 1),
  localparam int                YW          = $clog2(FB_HEIGHT + 1)
) (
  input  logic               clk_pixel,
  input  logic               rst_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic               active_draw_in,
  input  logic [1:0]         scale_sel,
  input  logic [XW-1:0]      px_x_in,
  input  logic [YW-1:0]      px_y_in,
  input  logic [PIXEL_W-1:0] px_color_in,
  input  logic               px_valid_in,
  output logic               px_ready_out,
  input  logic               swap_req_in,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               pixel_valid_out,
  output logic               front_sel_out,
  output logic               clearing_out,
  output logic               swap_pending_out,
  output logic [15:0]        drop_count_out
);

  localparam int DEPTH = FB_WIDTH * FB_HEIGHT;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FBW_A     = AW'(FB_WIDTH);
  localparam logic [XW-1:0] FBW_X     = XW'(FB_WIDTH);
  localparam logic [YW-1:0] FBH_Y     = YW'(FB_HEIGHT);
  localparam logic [10:0]   FBW_H     = 11'(FB_WIDTH);
  localparam logic [9:0]    FBH_V     = 10'(FB_HEIGHT);
  localparam logic [10:0]   H_LAST    = 11'(H_ACTIVE - 1);
  localparam logic [9:0]    V_LAST    = 10'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    ST_CLEAR     = 2'd0,
    ST_DRAW      = 2'd1,
    ST_WAIT_SWAP = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [AW-1:0]       clr_cnt_q, clr_cnt_d;
  logic                front_q, front_d;
  logic                pend_q, pend_d;
  logic [15:0]         drop_q, drop_d;

  // Registered write port: both clears and pixel writes land one edge after
  // they are issued. The target bank is captured with the address so a write
  // in flight across a swap still lands in the bank it was aimed at.
  logic                wr_en_q, wr_en_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [PIXEL_W-1:0]  wr_data_q, wr_data_d;
  logic                wr_bank_q;

  logic                px_in_range;
  logic [AW-1:0]       px_addr;
  logic                at_boundary;

  assign px_in_range = (px_x_in < FBW_X) && (px_y_in < FBH_Y);
  assign px_addr     = AW'(px_y_in) * FBW_A + AW'(px_x_in);
  assign at_boundary = (hcount_in == H_LAST) && (vcount_in == V_LAST);

  always_ff @(posedge clk_pixel or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      front_q   <= 1'b0;
      pend_q    <= 1'b0;
      drop_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_bank_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      front_q   <= front_d;
      pend_q    <= pend_d;
      drop_q    <= drop_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_bank_q <= ~front_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    front_d      = front_q;
    pend_d       = pend_q;
    drop_d       = drop_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    px_ready_out = 1'b0;
    clearing_out = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        clearing_out = 1'b1;
        wr_en_d      = 1'b1;
        wr_addr_d    = clr_cnt_q;
        wr_data_d    = CLEAR_COLOR;
        if (swap_req_in) begin
          pend_d = 1'b1;
        end
        if (clr_cnt_q == LAST_ADDR) begin
          clr_cnt_d = '0;
          // A request arriving on the last clear cycle counts as pending.
          state_d   = (pend_q || swap_req_in) ? ST_WAIT_SWAP : ST_DRAW;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      ST_DRAW: begin
        px_ready_out = 1'b1;
        if (px_valid_in) begin
          if (px_in_range) begin
            wr_en_d   = 1'b1;
            wr_addr_d = px_addr;
            wr_data_d = px_color_in;
          end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
        end
        if (swap_req_in) begin
          pend_d  = 1'b1;
          state_d = ST_WAIT_SWAP;
        end
      end

      ST_WAIT_SWAP: begin
        if (at_boundary) begin
          front_d = ~front_q;
          pend_d  = 1'b0;
          state_d = ST_CLEAR;
        end
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  assign front_sel_out    = front_q;
  assign swap_pending_out = pend_q;
  assign drop_count_out   = drop_q;

  // --------------------------------------------------------------------------
  // Scanout address stage
  // --------------------------------------------------------------------------
  logic [1:0]  shift;
  logic [10:0] sx;
  logic [9:0]  sy;
  logic        in_region;
  logic [AW-1:0] rd_addr_c;

  always_comb begin
    case (scale_sel)
      2'd0:    shift = 2'd0;
      2'd1:    shift = 2'd1;
      default: shift = 2'd2;
    endcase
  end

  assign sx        = hcount_in >> shift;
  assign sy        = vcount_in >> shift;
  assign in_region = active_draw_in && (sx < FBW_H) && (sy < FBH_V);
  // Out-of-region reads are parked on address 0 so the RAM index stays legal.
  assign rd_addr_c = in_region ? (AW'(sy) * FBW_A + AW'(sx)) : '0;

  logic [AW-1:0]      rd_addr_q;
  logic               rd_bank_q;
  logic               s1_valid_q;
  logic               s2_valid_q;
  logic [PIXEL_W-1:0] rd_data_q;

  // Stage 1 registers the address and the front bank; stage 2 is the RAM
  // read; stage 3 is the output register. The bank is captured at stage 1,
  // so a read issued on the boundary cycle still completes from the old bank.
  always_ff @(posedge clk_pixel or negedge rst_in) begin
    if (!rst_in) begin
      rd_addr_q       <= '0;
      rd_bank_q       <= 1'b0;
      s1_valid_q      <= 1'b0;
      s2_valid_q      <= 1'b0;
      pixel_out       <= '0;
      pixel_valid_out <= 1'b0;
    end else begin
      rd_addr_q       <= rd_addr_c;
      rd_bank_q       <= front_q;
      s1_valid_q      <= in_region;
      s2_valid_q      <= s1_valid_q;
      pixel_out       <= s2_valid_q ? rd_data_q : '0;
      pixel_valid_out <= s2_valid_q;
    end
  end

  // --------------------------------------------------------------------------
  // Storage: two banks, synchronous write and 1-cycle synchronous read
  // --------------------------------------------------------------------------
  logic [PIXEL_W-1:0] bank0 [DEPTH];
  logic [PIXEL_W-1:0] bank1 [DEPTH];

  always_ff @(posedge clk_pixel) begin
    if (wr_en_q && !wr_bank_q) begin
      bank0[wr_addr_q] <= wr_data_q;
    end
    if (wr_en_q && wr_bank_q) begin
      bank1[wr_addr_q] <= wr_data_q;
    end
    rd_data_q <= rd_bank_q ? bank1[rd_addr_q] : bank0[rd_addr_q];
  end

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl at FB 8x4, active video 32x16.
module tb_frame_buffer_ctrl;

  logic        clk_pixel = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        active_draw_in;
  logic [1:0]  scale_sel;
  logic [3:0]  px_x_in;
  logic [2:0]  px_y_in;
  logic [15:0] px_color_in;
  logic        px_valid_in;
  logic        px_ready_out;
  logic        swap_req_in;
  logic [15:0] pixel_out;
  logic        pixel_valid_out;
  logic        front_sel_out;
  logic        clearing_out;
  logic        swap_pending_out;
  logic [15:0] drop_count_out;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  frame_buffer_ctrl #(
    .FB_WIDTH (8),
    .FB_HEIGHT(4),
    .PIXEL_W  (16),
    .H_ACTIVE (32),
    .V_ACTIVE (16)
  ) dut (
    .clk_pixel       (clk_pixel),
    .rst_in          (rst_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .active_draw_in  (active_draw_in),
    .scale_sel       (scale_sel),
    .px_x_in         (px_x_in),
    .px_y_in         (px_y_in),
    .px_color_in     (px_color_in),
    .px_valid_in     (px_valid_in),
    .px_ready_out    (px_ready_out),
    .swap_req_in     (swap_req_in),
    .pixel_out       (pixel_out),
    .pixel_valid_out (pixel_valid_out),
    .front_sel_out   (front_sel_out),
    .clearing_out    (clearing_out),
    .swap_pending_out(swap_pending_out),
    .drop_count_out  (drop_count_out)
  );

  // Clock / watchdog
  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Checking
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic px_write(input logic [3:0] x, input logic [2:0] y, input logic [15:0] c,
                          input logic swap);
    px_x_in     = x;
    px_y_in     = y;
    px_color_in = c;
    px_valid_in = 1'b1;
    swap_req_in = swap;
    step();
    px_valid_in = 1'b0;
    swap_req_in = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req_in = 1'b1;
    step();
    swap_req_in = 1'b0;
  endtask

  task automatic hit_boundary();
    hcount_in = 11'd31;
    vcount_in = 10'd15;
    step();
    hcount_in = 11'd0;
    vcount_in = 10'd0;
  endtask

  // One isolated scanout read; the result is due three edges later.
  task automatic read_px(input logic [10:0] h, input logic [9:0] v, input logic act,
                         input logic [16:0] exp, input string tag);
    exp_q.push_back(exp);
    hcount_in      = h;
    vcount_in      = v;
    active_draw_in = act;
    step();
    hcount_in      = 11'd0;
    vcount_in      = 10'd0;
    active_draw_in = 1'b0;
    step();
    step();
    check_val(tag, 32'({pixel_valid_out, pixel_out}), 32'(exp_q.pop_front()));
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (clearing_out && n < 200) begin
      n++;
      step();
    end
  endtask

  localparam logic [16:0] V_RED   = {1'b1, 16'hF800};
  localparam logic [16:0] V_GREEN = {1'b1, 16'h07E0};
  localparam logic [16:0] V_BLUE  = {1'b1, 16'h001F};
  localparam logic [16:0] V_ZERO  = {1'b1, 16'h0000};
  localparam logic [16:0] NONE    = 17'h0;

  initial begin
    int n;
    int bad;
    logic [16:0] e;

    rst_in         = 1'b0;
    hcount_in      = '0;
    vcount_in      = '0;
    active_draw_in = 1'b0;
    scale_sel      = 2'd0;
    px_x_in        = '0;
    px_y_in        = '0;
    px_color_in    = '0;
    px_valid_in    = 1'b0;
    swap_req_in    = 1'b0;
    repeat (3) step();

    // Reset state
    check_val("rst_ready", 32'(px_ready_out), 32'd0);
    check_val("rst_clearing", 32'(clearing_out), 32'd1);
    check_val("rst_pending", 32'(swap_pending_out), 32'd0);
    check_val("rst_front", 32'(front_sel_out), 32'd0);
    check_val("rst_pixel", 32'({pixel_valid_out, pixel_out}), 32'd0);
    check_val("rst_drop", 32'(drop_count_out), 32'd0);

    // Initial clear lasts exactly 32 cycles
    rst_in = 1'b1;
    wait_clear(n);
    check_val("clr_len", 32'(n), 32'd32);
    check_val("ready_after_clr", 32'(px_ready_out), 32'd1);
    check_val("drop_init", 32'(drop_count_out), 32'd0);

    // Out-of-range writes are dropped and counted, saturating
    px_write(4'd8, 3'd0, 16'h1234, 1'b0);
    px_write(4'd0, 3'd4, 16'h5678, 1'b0);
    check_val("drop_two", 32'(drop_count_out), 32'd2);
    px_x_in     = 4'd8;
    px_y_in     = 3'd0;
    px_valid_in = 1'b1;
    repeat (65535) step();
    px_valid_in = 1'b0;
    check_val("drop_sat", 32'(drop_count_out), 32'hFFFF);

    // Draw, then a write on the same cycle as the swap request
    px_write(4'd3, 3'd2, 16'hF800, 1'b0);
    px_write(4'd5, 3'd1, 16'h07E0, 1'b1);
    check_val("wait_pending", 32'(swap_pending_out), 32'd1);
    check_val("wait_ready", 32'(px_ready_out), 32'd0);
    check_val("wait_front", 32'(front_sel_out), 32'd0);

    // Not the boundary: no swap
    hcount_in = 11'd31;
    vcount_in = 10'd14;
    step();
    hcount_in = 11'd0;
    vcount_in = 10'd0;
    check_val("no_swap_off_boundary", 32'(front_sel_out), 32'd0);

    hit_boundary();
    check_val("swap_front", 32'(front_sel_out), 32'd1);
    check_val("swap_pending_clr", 32'(swap_pending_out), 32'd0);
    check_val("swap_clearing", 32'(clearing_out), 32'd1);

    // Full 1x scan of the displayed bank
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (x == 3 && y == 2)      e = V_RED;
        else if (x == 5 && y == 1) e = V_GREEN;
        else                       e = V_ZERO;
        read_px(11'(x), 10'(y), 1'b1, e, "scan1x");
      end
    end
    read_px(11'd8, 10'd0, 1'b1, NONE, "out_h_1x");
    read_px(11'd0, 10'd4, 1'b1, NONE, "out_v_1x");
    read_px(11'd3, 10'd2, 1'b0, NONE, "blank_1x");

    // 2x
    scale_sel = 2'd1;
    read_px(11'd6, 10'd4, 1'b1, V_RED, "s2_6_4");
    read_px(11'd7, 10'd4, 1'b1, V_RED, "s2_7_4");
    read_px(11'd6, 10'd5, 1'b1, V_RED, "s2_6_5");
    read_px(11'd7, 10'd5, 1'b1, V_RED, "s2_7_5");
    read_px(11'd5, 10'd4, 1'b1, V_ZERO, "s2_5_4");
    read_px(11'd8, 10'd4, 1'b1, V_ZERO, "s2_8_4");
    read_px(11'd10, 10'd2, 1'b1, V_GREEN, "s2_10_2");
    read_px(11'd16, 10'd0, 1'b1, NONE, "s2_out_h");
    read_px(11'd0, 10'd8, 1'b1, NONE, "s2_out_v");

    // 4x (2 and 3)
    scale_sel = 2'd2;
    read_px(11'd12, 10'd8, 1'b1, V_RED, "s4_12_8");
    read_px(11'd15, 10'd11, 1'b1, V_RED, "s4_15_11");
    read_px(11'd11, 10'd8, 1'b1, V_ZERO, "s4_11_8");
    read_px(11'd20, 10'd4, 1'b1, V_GREEN, "s4_20_4");
    read_px(11'd31, 10'd15, 1'b1, V_ZERO, "s4_31_15");
    read_px(11'd32, 10'd0, 1'b1, NONE, "s4_out_h");
    scale_sel = 2'd3;
    read_px(11'd13, 10'd9, 1'b1, V_RED, "s3_13_9");
    scale_sel = 2'd0;

    check_val("draw_after_swap_clr", 32'(px_ready_out), 32'd1);

    // Second frame into bank 0, swap back
    px_write(4'd1, 3'd0, 16'h001F, 1'b0);
    pulse_swap();
    hit_boundary();
    check_val("swap2_front", 32'(front_sel_out), 32'd0);
    read_px(11'd1, 10'd0, 1'b1, V_BLUE, "bank0_1_0");
    read_px(11'd3, 10'd2, 1'b1, V_ZERO, "bank0_3_2");

    // Swap request during CLEAR
    pulse_swap();
    check_val("clr_req_pending", 32'(swap_pending_out), 32'd1);
    bad = 0;
    n = 0;
    while (clearing_out && n < 100) begin
      if (swap_pending_out !== 1'b1) bad++;
      n++;
      step();
    end
    check_val("pend_thru_clear", 32'(bad), 32'd0);
    check_val("clr_to_wait_ready", 32'(px_ready_out), 32'd0);
    repeat (5) step();
    check_val("wait_ready_held", 32'(px_ready_out), 32'd0);
    check_val("wait_pending_held", 32'(swap_pending_out), 32'd1);
    check_val("wait_not_clearing", 32'(clearing_out), 32'd0);
    hit_boundary();
    check_val("swap3_front", 32'(front_sel_out), 32'd1);
    check_val("swap3_pending", 32'(swap_pending_out), 32'd0);
    check_val("swap3_clearing", 32'(clearing_out), 32'd1);

    // Bank 1 was cleared while it was the back bank
    read_px(11'd3, 10'd2, 1'b1, V_ZERO, "bank1_cleared_3_2");
    read_px(11'd5, 10'd1, 1'b1, V_ZERO, "bank1_cleared_5_1");

    // Reset about 10 cycles into CLEAR, with scanout valid
    active_draw_in = 1'b1;
    repeat (4) step();
    check_val("pre_rst_valid", 32'(pixel_valid_out), 32'd1);
    rst_in = 1'b0;
    #1;
    check_val("mid_rst_clearing", 32'(clearing_out), 32'd1);
    check_val("mid_rst_ready", 32'(px_ready_out), 32'd0);
    check_val("mid_rst_front", 32'(front_sel_out), 32'd0);
    check_val("mid_rst_drop", 32'(drop_count_out), 32'd0);
    check_val("mid_rst_pixel", 32'({pixel_valid_out, pixel_out}), 32'd0);
    active_draw_in = 1'b0;
    repeat (3) step();
    rst_in = 1'b1;
    wait_clear(n);
    check_val("clr_len_again", 32'(n), 32'd32);
    check_val("ready_again", 32'(px_ready_out), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
